// File: rtl/qc_ldpc_pkg.sv
// Shared definitions for the QC-LDPC encoder scheduler: default code geometry
// and the scheduler state encoding.
package qc_ldpc_pkg;

  localparam int Z_DEF  = 15;
  localparam int NB_DEF = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_LOAD  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_OUT   = 3'd4
  } state_t;

endpackage

// File: rtl/qc_ldpc_mod_counter.sv
// Modulo-MOD counter with synchronous clear (priority) and increment; wrap
// flags the terminal count so the owner can chain counters.
module qc_ldpc_mod_counter #(
  parameter int MOD = 15,
  parameter int W   = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  logic [W-1:0] cnt_r;

  // count register: clear beats increment, terminal count rolls to zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (inc) begin
      if (cnt_r == W'(MOD - 1)) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + W'(1);
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt  = cnt_r;
  assign wrap = (cnt_r == W'(MOD - 1));

endmodule

// File: rtl/qc_ldpc_enc_scheduler.sv
// Control scheduler for a QC-LDPC parity encoder: sequences clear, per-block
// load and Z-cycle shift/accumulate phases, then hands parity downstream.
module qc_ldpc_enc_scheduler
  import qc_ldpc_pkg::*;
#(
  parameter int Z  = Z_DEF,
  parameter int NB = NB_DEF,
  localparam int CW = $clog2(Z),
  localparam int BW = $clog2(NB)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic          msg_valid,
  output logic          msg_ready,
  output logic          par_valid,
  input  logic          par_ready,
  output logic          clr_acc,
  output logic          load_sr,
  output logic          shift_en,
  output logic          acc_en,
  output logic [BW-1:0] blk_idx,
  output logic [CW-1:0] shift_cnt,
  output logic          busy,
  output logic          done
);

  state_t state_r;
  state_t state_s;
  logic   done_r;
  logic   shift_wrap_s;
  logic   blk_wrap_s;
  logic   shift_clr_s;
  logic   shift_inc_s;
  logic   blk_inc_s;

  // counters are held at zero outside a codeword so CLR always starts clean
  assign shift_clr_s = (state_r == ST_IDLE) || (state_r == ST_CLR) || abort;
  assign shift_inc_s = (state_r == ST_SHIFT);
  assign blk_inc_s   = (state_r == ST_SHIFT) && shift_wrap_s && !blk_wrap_s;

  qc_ldpc_mod_counter #(.MOD(Z), .W(CW)) u_shift_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (shift_clr_s),
    .inc   (shift_inc_s),
    .cnt   (shift_cnt),
    .wrap  (shift_wrap_s)
  );

  qc_ldpc_mod_counter #(.MOD(NB), .W(BW)) u_blk_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (shift_clr_s),
    .inc   (blk_inc_s),
    .cnt   (blk_idx),
    .wrap  (blk_wrap_s)
  );

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // next-state logic; abort overrides every other transition
  always_comb begin
    state_s = state_r;
    if (abort && (state_r != ST_IDLE)) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_s = ST_CLR;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_CLR: state_s = ST_LOAD;
        ST_LOAD: begin
          if (msg_valid) begin
            state_s = ST_SHIFT;
          end else begin
            state_s = ST_LOAD;
          end
        end
        ST_SHIFT: begin
          if (shift_wrap_s && blk_wrap_s) begin
            state_s = ST_OUT;
          end else if (shift_wrap_s) begin
            state_s = ST_LOAD;
          end else begin
            state_s = ST_SHIFT;
          end
        end
        ST_OUT: begin
          if (par_ready) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_OUT;
          end
        end
        default: state_s = ST_IDLE;
      endcase
    end
  end

  // done fires the cycle after parity is taken, never on an aborted codeword
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_r <= 1'b0;
    end else begin
      done_r <= (state_r == ST_OUT) && par_ready && !abort;
    end
  end

  assign msg_ready = (state_r == ST_LOAD);
  assign load_sr   = msg_ready && msg_valid;
  assign clr_acc   = (state_r == ST_CLR);
  assign shift_en  = (state_r == ST_SHIFT);
  assign acc_en    = (state_r == ST_SHIFT);
  assign par_valid = (state_r == ST_OUT);
  assign busy      = (state_r != ST_IDLE);
  assign done      = done_r;

endmodule
